// File: rtl/router_reg.sv
// Router datapath register: latches header, overflow byte and parity,
// forwards bytes to the destination FIFO and flags parity errors.
module router_reg (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] data_out,
  output logic       err,
  output logic       parity_done,
  output logic       low_packet_valid
);

  localparam int unsigned BW = 8;
  localparam logic [1:0] BAD_ADDR = 2'b11;

  logic [BW-1:0] hdr_q, hdr_d;
  logic [BW-1:0] full_q, full_d;
  logic [BW-1:0] pkt_par_q, pkt_par_d;
  logic [BW-1:0] int_par_q, int_par_d;
  logic [BW-1:0] dout_q, dout_d;
  logic          err_q, err_d;
  logic          pd_q, pd_d;
  logic          lpv_q, lpv_d;

  always_comb begin
    hdr_d = hdr_q;
    if (detect_add && pkt_valid
        && data_in[1:0] != BAD_ADDR)
      hdr_d = data_in;

    full_d = full_q;
    if (ld_state && fifo_full)
      full_d = data_in;

    pkt_par_d = pkt_par_q;
    if (ld_state && !pkt_valid)
      pkt_par_d = data_in;

    int_par_d = int_par_q;
    if (detect_add)
      int_par_d = '0;
    else if (lfd_state)
      int_par_d = int_par_q ^ hdr_q;
    else if (ld_state && pkt_valid
             && !full_state)
      int_par_d = int_par_q ^ data_in;
  end

  always_comb begin
    dout_d = dout_q;
    if (detect_add)
      dout_d = dout_q;
    else if (lfd_state)
      dout_d = hdr_q;
    else if (ld_state && !fifo_full)
      dout_d = data_in;
    else if (ld_state)
      dout_d = dout_q;
    else if (laf_state)
      dout_d = full_q;

    // A parity byte stalled by a full FIFO completes via LAF.
    pd_d = pd_q;
    if (detect_add)
      pd_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid)
             || (laf_state && lpv_q && !pd_q))
      pd_d = 1'b1;

    lpv_d = lpv_q;
    if (rst_int_reg)
      lpv_d = 1'b0;
    else if (ld_state && !pkt_valid)
      lpv_d = 1'b1;

    err_d = err_q;
    if (detect_add)
      err_d = 1'b0;
    else if (pd_q)
      err_d = (int_par_q != pkt_par_q);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q     <= '0;
      full_q    <= '0;
      pkt_par_q <= '0;
      int_par_q <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
      pd_q      <= 1'b0;
      lpv_q     <= 1'b0;
    end else begin
      hdr_q     <= hdr_d;
      full_q    <= full_d;
      pkt_par_q <= pkt_par_d;
      int_par_q <= int_par_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      pd_q      <= pd_d;
      lpv_q     <= lpv_d;
    end
  end

  assign data_out         = dout_q;
  assign err              = err_q;
  assign parity_done      = pd_q;
  assign low_packet_valid = lpv_q;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: packet-level model of FIFO byte stream,
// parity and status flags, checked every cycle.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] data_out;
  logic       err;
  logic       parity_done;
  logic       low_packet_valid;

  router_reg dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .data_out         (data_out),
    .err              (err),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid)
  );

  always #5 clock = ~clock;

  localparam logic [7:0] DA  = 8'h01;
  localparam logic [7:0] LFD = 8'h02;
  localparam logic [7:0] LD  = 8'h04;
  localparam logic [7:0] LAF = 8'h08;
  localparam logic [7:0] FS  = 8'h10;
  localparam logic [7:0] PV  = 8'h20;
  localparam logic [7:0] FF  = 8'h40;
  localparam logic [7:0] RI  = 8'h80;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: last byte handed to the FIFO and status flags.
  logic [7:0] e_data = 8'h00;
  logic       e_err  = 1'b0;
  logic       e_pd   = 1'b0;
  logic       e_lpv  = 1'b0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("data_out", data_out, e_data);
      chk("err", {7'd0, err}, {7'd0, e_err});
      chk("parity_done", {7'd0, parity_done},
          {7'd0, e_pd});
      chk("low_pkt_valid", {7'd0, low_packet_valid},
          {7'd0, e_lpv});
    end
  end

  task automatic drive(input logic [7:0] f,
                       input logic [7:0] d);
    detect_add  = f[0];
    lfd_state   = f[1];
    ld_state    = f[2];
    laf_state   = f[3];
    full_state  = f[4];
    pkt_valid   = f[5];
    fifo_full   = f[6];
    rst_int_reg = f[7];
    data_in     = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_model();
    e_data = '0;
    e_err  = 1'b0;
    e_pd   = 1'b0;
    e_lpv  = 1'b0;
  endtask

  // Whole packet through decode/lfd/ld, then a parity-check cycle.
  task automatic send_pkt(input logic [7:0] hdr,
                          input logic [7:0] pl[$],
                          input logic [7:0] par);
    logic [7:0] acc;
    acc = hdr;
    drive(DA | PV, hdr);
    tick();
    e_pd = 1'b0;
    e_err = 1'b0;
    drive(LFD | PV, 8'hFF);
    tick();
    e_data = hdr;
    foreach (pl[i]) begin
      drive(LD | PV, pl[i]);
      tick();
      e_data = pl[i];
      acc ^= pl[i];
    end
    drive(LD, par);
    tick();
    e_data = par;
    e_pd = 1'b1;
    e_lpv = 1'b1;
    drive(RI, 8'h00);
    tick();
    e_lpv = 1'b0;
    e_err = (acc != par);
    drive(8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] acc;

    resetn = 1'b0;
    drive(DA | PV | LD, 8'h5A);
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_err", {7'd0, err}, 8'h00);
    resetn = 1'b1;
    drive(8'h00, 8'h00);
    tick();

    // Good packet: header 3A, payload 5*i, parity 77.
    pl = {};
    for (int i = 0; i < 14; i++)
      pl.push_back(8'(5 * i));
    send_pkt(8'h3A, pl, 8'h77);
    chk("good_data", data_out, 8'h77);
    chk("good_pd", {7'd0, parity_done}, 8'h01);
    chk("good_err", {7'd0, err}, 8'h00);
    tick();

    // Same packet, wrong parity.
    send_pkt(8'h3A, pl, 8'h76);
    chk("bad_err", {7'd0, err}, 8'h01);
    tick();

    // Addr 11 header must not replace stored 3A.
    drive(DA | PV, 8'h3B);
    tick();
    e_pd = 1'b0;
    e_err = 1'b0;
    drive(LFD | PV, 8'h00);
    tick();
    e_data = 8'h3A;
    chk("bad_addr_hdr", data_out, 8'h3A);
    drive(8'h00, 8'h00);
    tick();

    // Packet with FIFO stalls, parity arriving while full.
    acc = 8'h0D;
    drive(DA | PV, 8'h0D);
    tick();
    drive(LFD | PV, 8'h00);
    tick();
    e_data = 8'h0D;
    drive(LD | PV, 8'h11);
    tick();
    e_data = 8'h11;
    acc ^= 8'h11;
    drive(LD | PV | FF, 8'd140);
    tick();
    acc ^= 8'd140;
    chk("full_hold", data_out, 8'h11);
    drive(LAF | PV, 8'h00);
    tick();
    e_data = 8'd140;
    chk("laf_data", data_out, 8'd140);
    drive(LD | PV, 8'h22);
    tick();
    e_data = 8'h22;
    acc ^= 8'h22;
    drive(LD | FF, acc);
    tick();
    e_lpv = 1'b1;
    chk("par_full_pd", {7'd0, parity_done}, 8'h00);
    drive(LAF, 8'h00);
    tick();
    e_data = acc;
    e_pd = 1'b1;
    chk("laf_par", data_out, 8'hB2);
    drive(RI, 8'h00);
    tick();
    e_lpv = 1'b0;
    e_err = 1'b0;
    chk("full_pkt_err", {7'd0, err}, 8'h00);
    chk("lpv_clear", {7'd0, low_packet_valid}, 8'h00);
    drive(8'h00, 8'h00);
    tick();

    // Reset in the middle of a load.
    drive(DA | PV, 8'h41);
    tick();
    e_pd = 1'b0;
    e_err = 1'b0;
    drive(LFD | PV, 8'h00);
    tick();
    e_data = 8'h41;
    drive(LD | PV, 8'h09);
    tick();
    e_data = 8'h09;
    resetn = 1'b0;
    drive(LD | PV | FF, 8'h0A);
    tick();
    zero_model();
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_pd", {7'd0, parity_done}, 8'h00);
    resetn = 1'b1;
    drive(DA | PV, 8'h3B);
    tick();
    drive(LFD | PV, 8'h00);
    tick();
    chk("rst_hdr", data_out, 8'h00);
    drive(8'h00, 8'h00);
    tick();

    // 16-byte packet after reset, correct parity.
    pl = {};
    acc = 8'h42;
    for (int i = 0; i < 16; i++) begin
      pl.push_back(8'(3 * i + 1));
      acc ^= 8'(3 * i + 1);
    end
    send_pkt(8'h42, pl, acc);
    chk("post_rst_err", {7'd0, err}, 8'h00);
    chk("post_rst_data", data_out, acc);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low, with ports named clock and resetn.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 pkt_valid  input  1  high while header/payload bytes are driven; low on the parity byte.
REQ-005 data_in  input  8  packet byte: header {len[5:0],addr[1:0]}, payload, or parity.
REQ-006 fifo_full  input  1  destination FIFO full.
REQ-007 detect_add, lfd_state, ld_state, laf_state, full_state  input  1 each  FSM state flags (DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, FIFO_FULL_STATE).
REQ-008 rst_int_reg  input  1  clears low_packet_valid.
REQ-009 data_out  output  8  byte written to the FIFO.
REQ-010 err  output  1  parity mismatch flag.
REQ-011 parity_done  output  1  parity byte received.
REQ-012 low_packet_valid  output  1  pkt_valid fell during a load.

Function
REQ-013 Internal 8-bit registers SHALL be: hdr_byte, full_byte, pkt_parity, int_parity.
REQ-014 hdr_byte SHALL load data_in when detect_add && pkt_valid && data_in[1:0]!=2'b11; otherwise it holds.
REQ-015 full_byte SHALL load data_in when ld_state && fifo_full; otherwise it holds.
REQ-016 pkt_parity SHALL load data_in when ld_state && !pkt_valid; otherwise it holds.
REQ-017 int_parity priority: detect_add -> 0; else lfd_state -> int_parity^hdr_byte; else ld_state && pkt_valid && !full_state -> int_parity^data_in; else hold.
REQ-018 data_out priority: detect_add -> hold; lfd_state -> hdr_byte; ld_state && !fifo_full -> data_in; ld_state && fifo_full -> hold; laf_state -> full_byte; else hold.
REQ-019 parity_done priority: detect_add -> 0; (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_packet_valid && !parity_done) -> 1; else hold.
REQ-020 low_packet_valid priority: rst_int_reg -> 0; ld_state && !pkt_valid -> 1; else hold.
REQ-021 err priority: detect_add -> 0; parity_done -> (int_parity != pkt_parity); else hold.
REQ-022 Latency: data_out, parity_done and low_packet_valid are registered, valid one clock after the qualifying input edge; err is valid one clock after parity_done rises.
REQ-023 Header with addr 2'b11 SHALL NOT update hdr_byte.
REQ-024 A parity byte arriving while fifo_full SHALL still be captured in pkt_parity and SHALL set parity_done via the laf_state path.

Reset
REQ-025 When resetn=0 at a rising edge, data_out, err, parity_done, low_packet_valid and all internal registers SHALL be 0, overriding every other input.
REQ-026 Reset mid-packet SHALL discard all partial parity/header state; the next packet starts from detect_add.

Structure
REQ-027 No shared package; widths (8-bit byte) are local parameters.
REQ-028 Single flat module, no sub-modules.

Verification
REQ-029 Good packet: header 8'h3A (len 14, addr 2), payload 5*i for i=0..13, parity 8'h77 -> data_out follows header then payload one cycle late, parity_done=1, err=0.
REQ-030 Bad parity: same packet with parity 8'h76 -> parity_done=1 then err=1 one cycle later.
REQ-031 FIFO full: ld_state=1, fifo_full=1, data_in=140 -> data_out holds previous value; then laf_state=1 -> data_out=140.
REQ-032 low_packet_valid: ld_state=1, pkt_valid=0 -> low_packet_valid=1; rst_int_reg=1 -> 0 next clock.
REQ-033 Invalid address: detect_add=1, pkt_valid=1, data_in=8'h3B -> hdr_byte unchanged.
REQ-034 Reset mid-packet: resetn=0 during ld_state -> all outputs 0 next clock; a following 16-byte packet is processed correctly.
